// File: rtl/ppu_pipelined_control_unit_if.sv
// ----------------------------------------------------------------------------
// ppu_pipelined_control_unit_if
// Bundles the ID-stage inputs and the ID/EX outputs of the PPU control unit.
//   master : drives instruction/stall/flush, observes the ex_* outputs and busy
//   slave  : the control unit itself
// Signals:
//   instruction[31:0] ID-stage instruction word
//   stall             hold the ID/EX register
//   flush             load a bubble into ID/EX
//   ex_ctrl[17:0]     registered control word
//   ex_rs/ex_rt[4:0]  registered source register fields
//   ex_dest[4:0]      registered destination register
//   ex_valid          ex_ctrl holds a real instruction
//   ex_illegal        registered unknown-opcode flag
//   busy              multicycle MULT/DIV sequence in progress
// ----------------------------------------------------------------------------
interface ppu_pipelined_control_unit_if;
  logic [31:0] instruction;
  logic        stall;
  logic        flush;
  logic [17:0] ex_ctrl;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dest;
  logic        ex_valid;
  logic        ex_illegal;
  logic        busy;

  modport master (
    output instruction, stall, flush,
    input  ex_ctrl, ex_rs, ex_rt, ex_dest, ex_valid, ex_illegal, busy
  );

  modport slave (
    input  instruction, stall, flush,
    output ex_ctrl, ex_rs, ex_rt, ex_dest, ex_valid, ex_illegal, busy
  );
endinterface

// File: rtl/ppu_pipelined_control_unit.sv
// ----------------------------------------------------------------------------
// ppu_pipelined_control_unit
// Decodes the ID-stage instruction into the 18-bit control word and registers
// it into the ID/EX control register, with stall and flush handling. An
// optional sequencer holds the front end while MULT/MULTU/DIV/DIVU run.
//
// Optional feature macro: PPU_MULDIV_EN
//   defined   : MULT/DIV sequencer (RUN -> BUSY -> WB -> RUN) present
//   undefined : no sequencer, busy tied low, MULT(U)/DIV(U) decode as illegal
//
// Parameters:
//   MUL_CYCLES  BUSY cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES  BUSY cycles for DIV/DIVU   (>= 1)
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  synchronous, active-low reset
//   bus    ppu_pipelined_control_unit_if.slave (instruction, stall, flush,
//          ex_ctrl, ex_rs, ex_rt, ex_dest, ex_valid, ex_illegal, busy)
//
// ex_ctrl layout: {SourceOperand[2:0], ALU_OP[3:0], B_Instr, Load_Instr,
//   RF_Enable, TA_Instr, MEM_Size[1:0], MEM_RW, MEM_SE, MEM_Enable,
//   Enable_HI, Enable_LO}
// ----------------------------------------------------------------------------
module ppu_pipelined_control_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  ppu_pipelined_control_unit_if.slave  bus
);

  if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cycles
    $error("MUL_CYCLES and DIV_CYCLES must be at least 1");
  end

  // Operand / ALU / size encodings
  localparam logic [2:0] SRC_RT    = 3'b000;
  localparam logic [2:0] SRC_SEXT  = 3'b001;
  localparam logic [2:0] SRC_ZEXT  = 3'b010;
  localparam logic [2:0] SRC_LUI   = 3'b011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1000;

  localparam logic [1:0] SZ_WORD   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_BYTE   = 2'b10;

  // Opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // REGIMM rt codes
  localparam logic [4:0] RI_BGEZ   = 5'h01;
  localparam logic [4:0] RI_BGEZAL = 5'h11;

`ifdef PPU_MULDIV_EN
  localparam logic [5:0]  F_MULT    = 6'h18;
  localparam logic [5:0]  F_MULTU   = 6'h19;
  localparam logic [5:0]  F_DIV     = 6'h1A;
  localparam logic [5:0]  F_DIVU    = 6'h1B;
  localparam logic [3:0]  ALU_MUL   = 4'b1001;
  localparam logic [3:0]  ALU_DIV   = 4'b1010;
  localparam logic [17:0] CTRL_HILO = 18'h00003;

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  // Keep at least one bit so the 1-cycle configuration still elaborates.
  localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dec_muldiv;
  logic               dec_div;
`endif

  // Instruction fields
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;

  assign opcode = bus.instruction[31:26];
  assign rs     = bus.instruction[25:21];
  assign rt     = bus.instruction[20:16];
  assign rd     = bus.instruction[15:11];
  assign shamt  = bus.instruction[10:6];
  assign funct  = bus.instruction[5:0];

  // Decoded control fields
  logic [2:0]  d_src;
  logic [3:0]  d_alu;
  logic        d_b, d_ld, d_rf, d_ta;
  logic [1:0]  d_size;
  logic        d_rw, d_se, d_men;
  logic        dec_legal;
  logic [4:0]  dec_dest;
  logic [17:0] dec_ctrl;

  // ID/EX registers
  logic [17:0] ex_ctrl_q, ex_ctrl_d;
  logic [4:0]  ex_rs_q, ex_rs_d;
  logic [4:0]  ex_rt_q, ex_rt_d;
  logic [4:0]  ex_dest_q, ex_dest_d;
  logic        ex_valid_q, ex_valid_d;
  logic        ex_illegal_q, ex_illegal_d;

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  always_comb begin
    d_src     = SRC_RT;
    d_alu     = ALU_ADD;
    d_b       = 1'b0;
    d_ld      = 1'b0;
    d_rf      = 1'b0;
    d_ta      = 1'b0;
    d_size    = SZ_WORD;
    d_rw      = 1'b0;
    d_se      = 1'b0;
    d_men     = 1'b0;
    dec_legal = 1'b1;
    dec_dest  = rt;
`ifdef PPU_MULDIV_EN
    dec_muldiv = 1'b0;
    dec_div    = 1'b0;
`endif

    case (opcode)
      OP_SPECIAL: begin
        dec_dest = rd;
        if (bus.instruction == 32'h0000_0000) begin
          // NOP: legal, all-zero control word
          dec_legal = 1'b1;
        end else if (shamt != 5'd0) begin
          // No supported SPECIAL op uses the shift amount field
          dec_legal = 1'b0;
        end else begin
          case (funct)
            F_ADDU:  begin d_rf = 1'b1; d_alu = ALU_ADD;   end
            F_SUBU:  begin d_rf = 1'b1; d_alu = ALU_SUB;   end
            F_AND:   begin d_rf = 1'b1; d_alu = ALU_AND;   end
            F_OR:    begin d_rf = 1'b1; d_alu = ALU_OR;    end
            F_XOR:   begin d_rf = 1'b1; d_alu = ALU_XOR;   end
            F_NOR:   begin d_rf = 1'b1; d_alu = ALU_NOR;   end
            F_SLT:   begin d_rf = 1'b1; d_alu = ALU_SLT;   end
            F_SLTU:  begin d_rf = 1'b1; d_alu = ALU_SLTU;  end
            F_MFHI,
            F_MFLO:  begin d_rf = 1'b1; d_alu = ALU_PASSB; end
            // Register-indirect jump: flagged as a jump target instruction
            F_JR:    begin d_ta = 1'b1; end
`ifdef PPU_MULDIV_EN
            F_MULT,
            F_MULTU: begin d_alu = ALU_MUL; dec_muldiv = 1'b1; end
            F_DIV,
            F_DIVU:  begin d_alu = ALU_DIV; dec_muldiv = 1'b1; dec_div = 1'b1; end
`endif
            default: dec_legal = 1'b0;
          endcase
        end
      end
      OP_REGIMM: begin
        case (rt)
          RI_BGEZ:   begin d_b = 1'b1; d_alu = ALU_SLT; end
          RI_BGEZAL: begin d_b = 1'b1; d_alu = ALU_SLT; d_rf = 1'b1; dec_dest = 5'd31; end
          default:   dec_legal = 1'b0;
        endcase
      end
      OP_J:     begin d_ta = 1'b1; end
      OP_JAL:   begin d_ta = 1'b1; d_rf = 1'b1; dec_dest = 5'd31; end
      OP_BEQ,
      OP_BNE:   begin d_b = 1'b1; d_alu = ALU_SUB; end
      OP_ADDIU: begin d_src = SRC_SEXT; d_alu = ALU_ADD;   d_rf = 1'b1; end
      OP_SLTI:  begin d_src = SRC_SEXT; d_alu = ALU_SLT;   d_rf = 1'b1; end
      OP_SLTIU: begin d_src = SRC_SEXT; d_alu = ALU_SLTU;  d_rf = 1'b1; end
      OP_ANDI:  begin d_src = SRC_ZEXT; d_alu = ALU_AND;   d_rf = 1'b1; end
      OP_ORI:   begin d_src = SRC_ZEXT; d_alu = ALU_OR;    d_rf = 1'b1; end
      OP_XORI:  begin d_src = SRC_ZEXT; d_alu = ALU_XOR;   d_rf = 1'b1; end
      OP_LUI:   begin d_src = SRC_LUI;  d_alu = ALU_PASSB; d_rf = 1'b1; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        d_src = SRC_SEXT;
        d_ld  = 1'b1;
        d_rf  = 1'b1;
        d_men = 1'b1;
        d_se  = (opcode == OP_LB) || (opcode == OP_LH);
        if (opcode == OP_LB || opcode == OP_LBU)      d_size = SZ_BYTE;
        else if (opcode == OP_LH || opcode == OP_LHU) d_size = SZ_HALF;
        else                                          d_size = SZ_WORD;
      end
      OP_SB, OP_SH, OP_SW: begin
        d_src = SRC_SEXT;
        d_rw  = 1'b1;
        d_men = 1'b1;
        if (opcode == OP_SB)      d_size = SZ_BYTE;
        else if (opcode == OP_SH) d_size = SZ_HALF;
        else                      d_size = SZ_WORD;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // HI/LO enables are only ever raised by the sequencer's WB step
  assign dec_ctrl = {d_src, d_alu, d_b, d_ld, d_rf, d_ta, d_size, d_rw, d_se, d_men, 2'b00};

  // --------------------------------------------------------------------------
  // Next-state logic. Defaults hold every register, which is the stall case.
  // --------------------------------------------------------------------------
  always_comb begin
    ex_ctrl_d    = ex_ctrl_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_dest_d    = ex_dest_q;
    ex_valid_d   = ex_valid_q;
    ex_illegal_d = ex_illegal_q;
`ifdef PPU_MULDIV_EN
    state_d      = state_q;
    cnt_d        = cnt_q;

    case (state_q)
      ST_RUN: begin
        if (bus.flush) begin
          ex_ctrl_d    = '0;
          ex_rs_d      = '0;
          ex_rt_d      = '0;
          ex_dest_d    = '0;
          ex_valid_d   = 1'b0;
          ex_illegal_d = 1'b0;
        end else if (!bus.stall) begin
          ex_ctrl_d    = dec_legal ? dec_ctrl : '0;
          ex_rs_d      = rs;
          ex_rt_d      = rt;
          ex_dest_d    = dec_dest;
          ex_valid_d   = dec_legal;
          ex_illegal_d = !dec_legal;
          if (dec_legal && dec_muldiv) begin
            state_d = ST_BUSY;
            cnt_d   = dec_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
          end
        end
      end
      // Flush is ignored here: the unit is the only owner of ID/EX until WB.
      ST_BUSY: begin
        if (!bus.stall) begin
          ex_ctrl_d    = '0;
          ex_rs_d      = '0;
          ex_rt_d      = '0;
          ex_dest_d    = '0;
          ex_valid_d   = 1'b0;
          ex_illegal_d = 1'b0;
          // The edge seen with counter==0 is the last bubble; WB follows.
          if (cnt_q == '0) state_d = ST_WB;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      // WB edge writes HI/LO; busy drops afterwards so the held instruction
      // is decoded on the following edge.
      ST_WB: begin
        if (!bus.stall) begin
          ex_ctrl_d    = CTRL_HILO;
          ex_rs_d      = '0;
          ex_rt_d      = '0;
          ex_dest_d    = '0;
          ex_valid_d   = 1'b1;
          ex_illegal_d = 1'b0;
          state_d      = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
`else
    if (bus.flush) begin
      ex_ctrl_d    = '0;
      ex_rs_d      = '0;
      ex_rt_d      = '0;
      ex_dest_d    = '0;
      ex_valid_d   = 1'b0;
      ex_illegal_d = 1'b0;
    end else if (!bus.stall) begin
      ex_ctrl_d    = dec_legal ? dec_ctrl : '0;
      ex_rs_d      = rs;
      ex_rt_d      = rt;
      ex_dest_d    = dec_dest;
      ex_valid_d   = dec_legal;
      ex_illegal_d = !dec_legal;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_ctrl_q    <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_dest_q    <= '0;
      ex_valid_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
`ifdef PPU_MULDIV_EN
      state_q      <= ST_RUN;
      cnt_q        <= '0;
`endif
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_dest_q    <= ex_dest_d;
      ex_valid_q   <= ex_valid_d;
      ex_illegal_q <= ex_illegal_d;
`ifdef PPU_MULDIV_EN
      state_q      <= state_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.ex_rs      = ex_rs_q;
  assign bus.ex_rt      = ex_rt_q;
  assign bus.ex_dest    = ex_dest_q;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_illegal = ex_illegal_q;
`ifdef PPU_MULDIV_EN
  assign bus.busy       = (state_q != ST_RUN);
`else
  assign bus.busy       = 1'b0;
`endif

endmodule

// File: tb/tb_ppu_pipelined_control_unit.sv
module tb_ppu_pipelined_control_unit;

  localparam logic [31:0] I_ADDU   = 32'h0085_1021;
  localparam logic [31:0] I_ADDIU  = 32'h2403_0005;
  localparam logic [31:0] I_LW     = 32'h8FA8_0004;
  localparam logic [31:0] I_SB     = 32'hA3A8_0000;
  localparam logic [31:0] I_LB     = 32'h80A2_0003;
  localparam logic [31:0] I_ORI    = 32'h34A2_FFFF;
  localparam logic [31:0] I_LUI    = 32'h3C01_1234;
  localparam logic [31:0] I_JAL    = 32'h0C00_0010;
  localparam logic [31:0] I_BEQ    = 32'h1085_0003;
  localparam logic [31:0] I_BGEZAL = 32'h04B1_0004;
  localparam logic [31:0] I_MULT   = 32'h0085_0018;
  localparam logic [31:0] I_DIV    = 32'h0085_001A;
  localparam logic [31:0] I_DIVU   = 32'h0085_001B;
  localparam logic [31:0] I_BAD    = 32'hFC00_0000;
  localparam logic [31:0] I_SLL1   = 32'h0000_0040;

  typedef struct packed {
    logic [17:0] ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        valid;
    logic        illegal;
    logic        busy;
    logic        chk_fields;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   pass_count  = 0;
  int   check_count = 0;
  exp_t sb_q[$];

  ppu_pipelined_control_unit_if bus_if ();

  ppu_pipelined_control_unit #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      pass_count++;
  endtask

  function automatic exp_t mk(input logic [17:0] c, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] dest, input logic v, input logic il,
                              input logic bz, input logic chk);
    exp_t e;
    e.ctrl = c; e.rs = rs; e.rt = rt; e.dest = dest;
    e.valid = v; e.illegal = il; e.busy = bz; e.chk_fields = chk;
    return e;
  endfunction

  // Drive one cycle of stimulus, queue its expected ID/EX contents, then
  // compare what the DUT registered on the edge.
  task automatic step(input string name, input logic rst_n, input logic [31:0] ins,
                      input logic st, input logic fl, input exp_t e);
    exp_t x;
    reset                 = rst_n;
    bus_if.instruction    = ins;
    bus_if.stall          = st;
    bus_if.flush          = fl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_eq({name, ".ctrl"},    32'(bus_if.ex_ctrl),    32'(x.ctrl));
    check_eq({name, ".valid"},   32'(bus_if.ex_valid),   32'(x.valid));
    check_eq({name, ".illegal"}, 32'(bus_if.ex_illegal), 32'(x.illegal));
    check_eq({name, ".busy"},    32'(bus_if.busy),       32'(x.busy));
    if (x.chk_fields) begin
      check_eq({name, ".rs"},   32'(bus_if.ex_rs),   32'(x.rs));
      check_eq({name, ".rt"},   32'(bus_if.ex_rt),   32'(x.rt));
      check_eq({name, ".dest"}, 32'(bus_if.ex_dest), 32'(x.dest));
    end
    $display("step %-14s instr=%08h stall=%0b flush=%0b -> ctrl=%05h valid=%0b ill=%0b busy=%0b",
             name, ins, st, fl, bus_if.ex_ctrl, bus_if.ex_valid, bus_if.ex_illegal, bus_if.busy);
  endtask

  initial begin
    reset              = 1'b0;
    bus_if.instruction = I_ADDU;
    bus_if.stall       = 1'b0;
    bus_if.flush       = 1'b0;

    // Reset and first decode
    step("rst0",    1'b0, I_ADDU, 1'b0, 1'b0, mk(18'h0, 0, 0, 0, 0, 0, 0, 1));
    step("rst1",    1'b0, I_ADDU, 1'b0, 1'b0, mk(18'h0, 0, 0, 0, 0, 0, 0, 1));
    step("addu",    1'b1, I_ADDU, 1'b0, 1'b0, mk(18'h00100, 4, 5, 2, 1, 0, 0, 1));
    step("addiu",   1'b1, I_ADDIU, 1'b0, 1'b0, mk(18'h08100, 0, 3, 3, 1, 0, 0, 1));
    step("lw",      1'b1, I_LW,   1'b0, 1'b0, mk(18'h08304, 29, 8, 8, 1, 0, 0, 1));

    // Stall holds the LW for three edges, then flush beats stall
    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i), 1'b1, I_ADDU, 1'b1, 1'b0, mk(18'h08304, 29, 8, 8, 1, 0, 0, 1));
    step("flush_stall", 1'b1, I_ADDU, 1'b1, 1'b1, mk(18'h0, 0, 0, 0, 0, 0, 0, 0));

    // Assorted decodes
    step("sb",      1'b1, I_SB,     1'b0, 1'b0, mk(18'h08054, 29, 8, 8, 1, 0, 0, 1));
    step("lb",      1'b1, I_LB,     1'b0, 1'b0, mk(18'h0834C, 5, 2, 2, 1, 0, 0, 1));
    step("ori",     1'b1, I_ORI,    1'b0, 1'b0, mk(18'h11900, 5, 2, 2, 1, 0, 0, 1));
    step("lui",     1'b1, I_LUI,    1'b0, 1'b0, mk(18'h1C100, 0, 1, 1, 1, 0, 0, 1));
    step("jal",     1'b1, I_JAL,    1'b0, 1'b0, mk(18'h00180, 0, 0, 31, 1, 0, 0, 1));
    step("beq",     1'b1, I_BEQ,    1'b0, 1'b0, mk(18'h00C00, 4, 5, 5, 1, 0, 0, 1));
    step("bgezal",  1'b1, I_BGEZAL, 1'b0, 1'b0, mk(18'h03500, 5, 17, 31, 1, 0, 0, 1));
    step("nop",     1'b1, 32'h0,    1'b0, 1'b0, mk(18'h0, 0, 0, 0, 1, 0, 0, 1));
    step("illegal", 1'b1, I_BAD,    1'b0, 1'b0, mk(18'h0, 0, 0, 0, 0, 1, 0, 0));
    step("sll_bad", 1'b1, I_SLL1,   1'b0, 1'b0, mk(18'h0, 0, 0, 0, 0, 1, 0, 0));
    step("flush",   1'b1, I_ADDU,   1'b0, 1'b1, mk(18'h0, 0, 0, 0, 0, 0, 0, 0));

`ifdef PPU_MULDIV_EN
    // Flushed MULT must not start the sequencer
    step("mult_flush", 1'b1, I_MULT, 1'b0, 1'b1, mk(18'h0, 0, 0, 0, 0, 0, 0, 0));

    // MULT: issue, 4 bubbles (one with an ignored flush), WB, held ADDU
    step("mult_issue", 1'b1, I_MULT, 1'b0, 1'b0, mk(18'h04800, 4, 5, 0, 1, 0, 1, 1));
    for (int i = 0; i < 4; i++)
      step($sformatf("mult_busy%0d", i), 1'b1, I_ADDU, 1'b0, (i == 1),
           mk(18'h0, 0, 0, 0, 0, 0, 1, 0));
    step("mult_wb",    1'b1, I_ADDU, 1'b0, 1'b0, mk(18'h00003, 0, 0, 0, 1, 0, 0, 0));
    step("mult_after", 1'b1, I_ADDU, 1'b0, 1'b0, mk(18'h00100, 4, 5, 2, 1, 0, 0, 1));

    // DIVU: 8 bubbles with one stalled edge in between, then WB
    step("divu_issue", 1'b1, I_DIVU, 1'b0, 1'b0, mk(18'h05000, 4, 5, 0, 1, 0, 1, 1));
    for (int i = 0; i < 9; i++)
      step($sformatf("divu_busy%0d", i), 1'b1, I_ADDU, (i == 3), 1'b0,
           mk(18'h0, 0, 0, 0, 0, 0, 1, 0));
    step("divu_wb",    1'b1, I_ADDU, 1'b0, 1'b0, mk(18'h00003, 0, 0, 0, 1, 0, 0, 0));
    step("divu_after", 1'b1, I_ADDU, 1'b0, 1'b0, mk(18'h00100, 4, 5, 2, 1, 0, 0, 1));

    // DIV aborted by reset while BUSY
    step("div_issue",  1'b1, I_DIV,  1'b0, 1'b0, mk(18'h05000, 4, 5, 0, 1, 0, 1, 1));
    step("div_busy",   1'b1, I_ADDU, 1'b0, 1'b0, mk(18'h0, 0, 0, 0, 0, 0, 1, 0));
    step("div_reset",  1'b0, I_ADDU, 1'b0, 1'b0, mk(18'h0, 0, 0, 0, 0, 0, 0, 1));
    step("div_resume", 1'b1, I_ADDU, 1'b0, 1'b0, mk(18'h00100, 4, 5, 2, 1, 0, 0, 1));
`else
    // Without the sequencer MULT/DIV are unknown opcodes and busy stays low
    step("mult_ill",   1'b1, I_MULT, 1'b0, 1'b0, mk(18'h0, 0, 0, 0, 0, 1, 0, 0));
    step("mult_next",  1'b1, I_ADDU, 1'b0, 1'b0, mk(18'h00100, 4, 5, 2, 1, 0, 0, 1));
    step("div_ill",    1'b1, I_DIV,  1'b0, 1'b0, mk(18'h0, 0, 0, 0, 0, 1, 0, 0));
    step("div_next",   1'b1, I_ADDU, 1'b0, 1'b0, mk(18'h00100, 4, 5, 2, 1, 0, 0, 1));
`endif

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
